// File: rtl/sa_row_feeder_pkg.sv
// Shared types for the systolic-array row feeder: FSM encoding and beat-bus layout.
// A beat is packed as {cmd, valid, data}, with cmd in the MSB.
package sa_row_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } fsm_state_e;

    // Control bits prepended to the data field of a beat: {cmd, valid}.
    localparam int BEAT_CTRL_W = 2;

    // The row pipeline needs NUM_PE+1 cycles to drain, plus the row's own skew.
    function automatic int flush_cycles(input int num_pe, input int row_skew);
        return num_pe + row_skew + 32'sd1;
    endfunction

endpackage

// File: rtl/sa_skew_delay.sv
// Fixed-depth shift register that delays the beat bus by the row index.
// DEPTH=0 degenerates to a plain wire.
module sa_skew_delay #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk & rst_n;
            assign o_data = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_q [DEPTH];

            // Shift chain; every stage clears on reset so no stale beat survives an abort.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe_q[i] <= {WIDTH{1'b0}};
                    end
                end else begin
                    pipe_q[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign o_data = pipe_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_row_feeder.sv
// Left-edge transmitter for one systolic-array row: loads NUM_PE weights (cmd=1),
// streams activations (cmd=0), then waits for the row pipeline to drain.
module sa_row_feeder
    import sa_row_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PE     = 4,
    parameter int ROW_SKEW   = 0,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    output logic [DATA_WIDTH-1:0] o_data_left,
    output logic                  o_valid_left,
    output logic                  o_cmd,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int WCNT_W    = $clog2(NUM_PE + 1);
    localparam int FCNT_W    = $clog2(NUM_PE + ROW_SKEW + 2);
    localparam int BEAT_W    = DATA_WIDTH + BEAT_CTRL_W;
    localparam int FLUSH_CYC = flush_cycles(NUM_PE, ROW_SKEW);

    localparam logic [WCNT_W-1:0]    WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [WCNT_W-1:0]    WCNT_ONE  = WCNT_W'(1'b1);
    localparam logic [WCNT_W-1:0]    WCNT_LAST = WCNT_W'(NUM_PE - 32'sd1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] ACNT_ONE  = LEN_WIDTH'(1'b1);
    localparam logic [FCNT_W-1:0]    FCNT_ZERO = {FCNT_W{1'b0}};
    localparam logic [FCNT_W-1:0]    FCNT_ONE  = FCNT_W'(1'b1);
    localparam logic [FCNT_W-1:0]    FCNT_LAST = FCNT_W'(FLUSH_CYC - 32'sd1);
    localparam logic [BEAT_W-1:0]    BEAT_IDLE = {BEAT_W{1'b0}};

    fsm_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [LEN_WIDTH-1:0] acnt_q, acnt_d;
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
    logic                 w_ready_q, w_ready_d;
    logic                 a_ready_q, a_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [BEAT_W-1:0]    beat_pins_s;
    logic                 w_hs_s;
    logic                 a_hs_s;

    assign w_hs_s = w_valid & w_ready_q;
    assign a_hs_s = a_valid & a_ready_q;

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= LEN_ZERO;
            wcnt_q    <= WCNT_ZERO;
            acnt_q    <= LEN_ZERO;
            fcnt_q    <= FCNT_ZERO;
            w_ready_q <= 1'b0;
            a_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            beat_q    <= BEAT_IDLE;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wcnt_q    <= wcnt_d;
            acnt_q    <= acnt_d;
            fcnt_q    <= fcnt_d;
            w_ready_q <= w_ready_d;
            a_ready_q <= a_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            beat_q    <= beat_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        acnt_d  = acnt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    len_d   = i_len;
                    wcnt_d  = WCNT_ZERO;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_hs_s) begin
                    wcnt_d = wcnt_q + WCNT_ONE;
                    if (wcnt_q == WCNT_LAST) begin
                        acnt_d  = LEN_ZERO;
                        fcnt_d  = FCNT_ZERO;
                        state_d = (len_q != LEN_ZERO) ? ST_STREAM : ST_FLUSH;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_STREAM: begin
                if (a_hs_s) begin
                    acnt_d = acnt_q + ACNT_ONE;
                    if (acnt_d == len_q) begin
                        fcnt_d  = FCNT_ZERO;
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == FCNT_LAST) begin
                    fcnt_d  = FCNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d  = fcnt_q + FCNT_ONE;
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        w_ready_d = (state_d == ST_LOAD);
        a_ready_d = (state_d == ST_STREAM);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_FLUSH) && (fcnt_d == FCNT_LAST);
        if (w_hs_s) begin
            beat_d = {1'b1, 1'b1, w_data};
        end else if (a_hs_s) begin
            beat_d = {1'b0, 1'b1, a_data};
        end else begin
            beat_d = BEAT_IDLE;
        end
    end

    sa_skew_delay #(
        .WIDTH (BEAT_W),
        .DEPTH (ROW_SKEW)
    ) u_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (beat_q),
        .o_data (beat_pins_s)
    );

    assign w_ready      = w_ready_q;
    assign a_ready      = a_ready_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_cmd        = beat_pins_s[BEAT_W-1];
    assign o_valid_left = beat_pins_s[BEAT_W-2];
    assign o_data_left  = beat_pins_s[DATA_WIDTH-1:0];

endmodule
